// File: rtl/sipo_pack_pkg.sv
// Shared defaults for the SIPO packer and the PISO that feeds it.
// Holds the default widths/depths and a helper for the serial beat width.
// Optional flush support elsewhere in this slice is enabled by defining SIPO_FLUSH_EN.
package sipo_pack_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_PE_NUM     = 4;
    localparam int unsigned DEF_PACK_NUM   = 4;
    localparam int unsigned DEF_FIFO_DEPTH = 8;

    // One serial beat carries a complex sample: real and imaginary parts.
    function automatic int unsigned beat_width(input int unsigned data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/sipo_pack_if.sv
// Stream/handshake bundle between the PISO, the packer and the output DMA.
// Signals:
//   s_in_v / s_in         serial beat from the PISO (no backpressure)
//   m_out_v / m_out       packed word at the FIFO head
//   m_out_rdy             consumer ready
//   fill_level            FIFO occupancy
//   overflow              sticky dropped-word flag
//   flush                 force out a partial burst (only with SIPO_FLUSH_EN)
// Modports: master = producer/consumer side (bench, DMA), slave = packer.
interface sipo_pack_if
    import sipo_pack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned PACK_NUM   = DEF_PACK_NUM,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
);

    localparam int unsigned BW = beat_width(DATA_WIDTH);
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

    logic                   s_in_v;
    logic [BW-1:0]          s_in;
    logic                   m_out_v;
    logic [PACK_NUM*BW-1:0] m_out;
    logic                   m_out_rdy;
    logic [LW-1:0]          fill_level;
    logic                   overflow;
`ifdef SIPO_FLUSH_EN
    logic                   flush;

    modport master (
        output s_in_v, s_in, m_out_rdy, flush,
        input  m_out_v, m_out, fill_level, overflow
    );

    modport slave (
        input  s_in_v, s_in, m_out_rdy, flush,
        output m_out_v, m_out, fill_level, overflow
    );
`else
    modport master (
        output s_in_v, s_in, m_out_rdy,
        input  m_out_v, m_out, fill_level, overflow
    );

    modport slave (
        input  s_in_v, s_in, m_out_rdy,
        output m_out_v, m_out, fill_level, overflow
    );
`endif

endinterface

// File: rtl/sipo_pack_sync_fifo.sv
// sync_fifo: single-clock FIFO of packed words.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
// A push while full is accepted when a pop happens in the same cycle.
// The head is read combinationally from registered storage.
// Ports:
//   clk, rst    clock, async active-high reset
//   push, din   write request and data
//   pop         read request (ignored when empty)
//   dout        current head word
//   full, empty status flags
//   count       occupancy 0..DEPTH
module sync_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        count   = wr_ptr - rd_ptr;
        dout    = mem[rd_ptr[AW-1:0]];
        do_pop  = pop && !empty;
        // The slot freed by a same-cycle pop lets a push into a full FIFO succeed.
        do_push = push && (!full || do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sipo_pack.sv
// sipo_pack: collects serial complex beats from the PISO into PACK_NUM-beat
// words (beat k -> lane k, lane 0 in the LSBs), buffers them in a FIFO and
// presents them on a valid/ready port. Words that arrive while the FIFO is
// full and not being drained are dropped and flagged on a sticky overflow.
// Ports:
//   clk, rst    clock, async active-high reset (discards any partial burst)
//   bus         sipo_pack_if.slave: s_in_v/s_in in, m_out_v/m_out/m_out_rdy out,
//               fill_level, overflow, and flush when SIPO_FLUSH_EN is defined
// SIPO_FLUSH_EN: adds flush, which pushes a partial burst with zeroed upper lanes.
module sipo_pack
    import sipo_pack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned PACK_NUM   = DEF_PACK_NUM,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    sipo_pack_if.slave bus
);

    localparam int unsigned BW = beat_width(DATA_WIDTH);
    localparam int unsigned WW = PACK_NUM * BW;
    localparam int unsigned CW = $clog2(PACK_NUM);
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

    logic [CW-1:0] cnt;
    logic [WW-1:0] partial;
    logic [WW-1:0] word_c;
    logic          last_beat;
    logic          flush_c;
    logic          push;
    logic          pop;
    logic          overflow_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic [WW-1:0] fifo_dout;
    logic [LW-1:0] fifo_count;

`ifdef SIPO_FLUSH_EN
    always_comb flush_c = bus.flush;
`else
    always_comb flush_c = 1'b0;
`endif

    always_comb begin
        // Merge this cycle's beat into its lane; the result is both the next
        // partial value and the word pushed on completion/flush.
        word_c = partial;
        if (bus.s_in_v) begin
            word_c[cnt*BW +: BW] = bus.s_in;
        end
        last_beat = bus.s_in_v && (cnt == CW'(PACK_NUM - 1));
        // Flush only pushes if something is pending after counting this beat;
        // a beat that completes the burst already pushes, so no second push.
        push = last_beat || (flush_c && (cnt != '0 || bus.s_in_v));
        pop  = !fifo_empty && bus.m_out_rdy;
    end

    // Partial is cleared on every push so lanes not reached before a flush read as 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            partial    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                cnt     <= '0;
                partial <= '0;
            end else if (bus.s_in_v) begin
                cnt     <= cnt + CW'(1);
                partial <= word_c;
            end
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (word_c),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        bus.m_out_v    = !fifo_empty;
        bus.m_out      = fifo_dout;
        bus.fill_level = fifo_count;
        bus.overflow   = overflow_q;
    end

endmodule
